// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver and the transmit path:
//   - uart_state_e : receiver frame states
//   - OS_RATE      : oversampling ticks per bit
//   - SMP_FIRST/SMP_MID/SMP_LAST : oversample positions voted on each bit
//   - calc_div()   : clock cycles per oversample tick
// No ports.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  localparam int OS_RATE   = 16;
  localparam int SMP_FIRST = 7;
  localparam int SMP_MID   = 8;
  localparam int SMP_LAST  = 9;

  // Clock cycles per oversample tick, truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// -----------------------------------------------------------------------------
// uart_rx_os_if
// Byte delivery bundle between the UART receiver and its consumer.
//   rx_data      : received byte, stable while rx_valid is high
//   rx_valid     : byte available, held until accepted
//   rx_ready     : consumer accepts when rx_valid & rx_ready at a clk edge
//   rx_frame_err : one-cycle pulse, stop bit sampled low
//   rx_overrun   : one-cycle pulse, byte completed while rx_valid still high
//   rx_busy      : receiver is inside a frame or waiting out a break
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_os_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_overrun,
    output rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_overrun,
    input  rx_busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Oversample tick generator: counts 0..DIV-1 and raises tick for one cycle at
// the terminal count. restart forces the count back to 0 so the tick phase can
// be aligned to an external event (a detected start edge).
//   clk     : system clock
//   rst     : synchronous active-high reset
//   restart : clear the counter this cycle
//   tick    : one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// 8N1 UART receiver, 16x oversampling, 3-sample majority vote on every bit.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   uart_rxd  : asynchronous serial input, idle high
//   rx_if     : byte/handshake/status bundle (master side)
// Parameters: clk_freq (Hz), uart_baud_rate (bit/s).
// -----------------------------------------------------------------------------
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 115200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         uart_rxd,
  uart_rx_os_if.master rx_if
);

  localparam int DIV = calc_div(clk_freq, uart_baud_rate);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_os: clk_freq / (uart_baud_rate * 16) must be at least 1");
  end

  logic        r_sync_p0;
  logic        r_sync_p1;
  logic        w_rxs;

  uart_state_e r_state;
  uart_state_e w_state_nxt;

  logic [3:0]  r_os;
  logic [2:0]  r_bit;
  logic        r_smp7;
  logic        r_smp8;
  logic [7:0]  r_shift;

  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_ovr;

  logic        w_tick;
  logic        w_dec;
  logic        w_wrap;
  logic        w_maj;
  logic        w_restart;
  logic        w_load;
  logic        w_overrun;
  logic        w_frame_err;
  logic        w_shift_en;

  // ---- input synchroniser: two flops, idle-high reset ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= uart_rxd;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_rxs = r_sync_p1;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // Events are keyed on the os value before the tick advances it, so the
  // tick that moves os to 7/8/9 is the one that samples.
  assign w_dec  = w_tick && (r_os == 4'(SMP_LAST - 1));
  assign w_wrap = w_tick && (r_os == 4'(OS_RATE - 1));
  // Third vote is the live bit on the deciding tick.
  assign w_maj  = (r_smp7 & r_smp8) | (r_smp7 & w_rxs) | (r_smp8 & w_rxs);

  // ---- oversample and bit counters ----
  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_os  <= '0;
      r_bit <= '0;
    end else if (w_tick) begin
      r_os <= r_os + 4'd1;
      if (w_wrap && (r_state == DATA)) begin
        r_bit <= r_bit + 3'd1;
      end
    end
  end

  // ---- vote samples and shift register ----
  always_ff @(posedge clk) begin
    if (w_tick && (r_os == 4'(SMP_FIRST - 1))) begin
      r_smp7 <= w_rxs;
    end
    if (w_tick && (r_os == 4'(SMP_MID - 1))) begin
      r_smp8 <= w_rxs;
    end
    if (w_shift_en) begin
      r_shift <= {w_maj, r_shift[7:1]};
    end
  end

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- FSM next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_rxs) w_state_nxt = START;
      end
      START: begin
        // A start bit that votes high was a glitch.
        if (w_dec && w_maj)  w_state_nxt = IDLE;
        else if (w_wrap)     w_state_nxt = DATA;
      end
      DATA: begin
        if (w_wrap && (r_bit == 3'd7)) w_state_nxt = STOP;
      end
      STOP: begin
        // Leave at mid-stop-bit so a following start edge is not missed.
        if (w_dec) w_state_nxt = w_maj ? IDLE : BREAK;
      end
      BREAK: begin
        // Hold off until the line returns high so a break is not re-read
        // as a stream of start bits.
        if (w_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
    w_restart   = 1'b0;
    w_load      = 1'b0;
    w_overrun   = 1'b0;
    w_frame_err = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      IDLE: begin
        w_restart = !w_rxs;
      end
      DATA: begin
        w_shift_en = w_dec;
      end
      STOP: begin
        if (w_dec) begin
          if (w_maj) begin
            // An accept landing on the same edge frees the holding register.
            if (!r_valid || rx_if.rx_ready) w_load    = 1'b1;
            else                            w_overrun = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---- output holding register and status pulses ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_frame_err;
      r_ovr  <= w_overrun;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data      = r_data;
  assign rx_if.rx_valid     = r_valid;
  assign rx_if.rx_frame_err = r_ferr;
  assign rx_if.rx_overrun   = r_ovr;
  assign rx_if.rx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Directed bench for uart_rx_os at DIV=10 (160 clk per bit). A behavioural
// receiver model tracks elapsed time since each detected start edge and votes
// on the samples at 7/8/9 sixteenths of every bit; a compare process checks
// every DUT output against it on every cycle. Literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 312500;
  localparam int DIV      = 10;
  localparam int BIT      = 16 * DIV;
  localparam int LAT      = 1533;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  uart_rx_os_if rx_if();

  uart_rx_os #(
    .clk_freq       (CLK_FREQ),
    .uart_baud_rate (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (rxd),
    .rx_if    (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_busy  = 1'b0;

  initial begin : model
    bit       q1, q2, s, s7, s8, maj, acc, ld;
    int       phase, t, b, r;
    bit [7:0] mbyte;
    q1 = 1'b1; q2 = 1'b1; phase = 0; t = 0; s7 = 1'b1; s8 = 1'b1; mbyte = '0;
    forever begin
      @(posedge clk);
      cyc++;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rst) begin
        q1 = 1'b1; q2 = 1'b1;
        m_valid = 1'b0; m_data = 8'h00;
        phase = 0; t = 0;
      end else begin
        s  = q2; q2 = q1; q1 = rxd;
        acc = m_valid && rx_if.rx_ready;
        ld  = 1'b0;
        if (phase == 0) begin
          if (!s) begin phase = 1; t = 0; end
        end else if (phase == 1) begin
          t++;
          b = t / BIT;
          r = t % BIT;
          if (r == 7 * DIV) s7 = s;
          if (r == 8 * DIV) s8 = s;
          if (r == 9 * DIV) begin
            maj = (int'(s7) + int'(s8) + int'(s)) >= 2;
            if (b == 0) begin
              if (maj) phase = 0;
            end else if (b <= 8) begin
              mbyte[b-1] = maj;
            end else begin
              if (maj) begin
                phase = 0;
                if (!m_valid || acc) ld = 1'b1;
                else                 m_ovr = 1'b1;
              end else begin
                phase  = 2;
                m_ferr = 1'b1;
              end
            end
          end
        end else begin
          if (s) phase = 0;
        end
        if (ld) begin
          m_valid = 1'b1;
          m_data  = mbyte;
        end else if (acc) begin
          m_valid = 1'b0;
        end
      end
      m_busy = (phase != 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("rx_valid",     32'(rx_if.rx_valid),     32'(m_valid));
        chk("rx_data",      32'(rx_if.rx_data),      32'(m_data));
        chk("rx_frame_err", 32'(rx_if.rx_frame_err), 32'(m_ferr));
        chk("rx_overrun",   32'(rx_if.rx_overrun),   32'(m_ovr));
        chk("rx_busy",      32'(rx_if.rx_busy),      32'(m_busy));
      end
    end
  end

  // ---------------- event counters for literal checks ----------------
  int         n_rise = 0, n_vhi = 0, n_ferr = 0, n_ovr = 0, n_busy = 0, rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;

  initial begin : monitor
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_if.rx_valid === 1'b1 && prev_v !== 1'b1) begin
          n_rise++;
          rise_cyc  = cyc;
          rise_data = rx_if.rx_data;
        end
        if (rx_if.rx_valid === 1'b1)     n_vhi++;
        if (rx_if.rx_frame_err === 1'b1) n_ferr++;
        if (rx_if.rx_overrun === 1'b1)   n_ovr++;
        if (rx_if.rx_busy === 1'b1)      n_busy++;
      end
      prev_v = rx_if.rx_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at the current negedge. g_from/g_len invert the
  // line over that clk window; rst_at pulses reset at that offset and abandons
  // the frame with the line idle.
  task automatic send_frame(input logic [7:0] b, input bit stopv,
                            input int g_from, input int g_len, input int rst_at);
    for (int t = 0; t < 10 * BIT; t++) begin
      bit v;
      if (t == rst_at) begin
        rxd = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (t < BIT)          v = 1'b0;
      else if (t < 9 * BIT) v = b[t / BIT - 1];
      else                  v = stopv;
      if (t >= g_from && t < g_from + g_len) v = ~v;
      rxd = v;
      @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int s_rise, s_vhi, s_ferr, s_ovr, s_busy, t0, lat;
    rx_if.rx_ready = 1'b1;
    rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_valid", 32'(rx_if.rx_valid),     0);
    chk("reset_data",  32'(rx_if.rx_data),      0);
    chk("reset_ferr",  32'(rx_if.rx_frame_err), 0);
    chk("reset_ovr",   32'(rx_if.rx_overrun),   0);
    chk("reset_busy",  32'(rx_if.rx_busy),      0);
    rst = 1'b0;
    idle(20);

    // 0xA5 with consumer ready: single-cycle valid pulse, fixed latency
    s_rise = n_rise; s_vhi = n_vhi; s_ferr = n_ferr; s_ovr = n_ovr;
    t0 = cyc;
    send_frame(8'hA5, 1'b1, -1, 0, -1);
    idle(40);
    lat = rise_cyc - t0;
    chk("a5_rises",   32'(n_rise - s_rise), 1);
    chk("a5_data",    32'(rise_data),       32'h A5);
    chk("a5_width",   32'(n_vhi - s_vhi),   1);
    chk("a5_latency_in_window", 32'(lat >= LAT - DIV && lat <= LAT + DIV), 1);
    chk("a5_no_err",  32'((n_ferr - s_ferr) + (n_ovr - s_ovr)), 0);
    chk("model_a5",   32'(m_data), 32'h A5);

    // 0x3C then 0xC3 back to back, not accepted: first held, one overrun
    rx_if.rx_ready = 1'b0;
    s_rise = n_rise; s_ovr = n_ovr;
    send_frame(8'h3C, 1'b1, -1, 0, -1);
    send_frame(8'hC3, 1'b1, -1, 0, -1);
    idle(40);
    chk("ovr_valid_held", 32'(rx_if.rx_valid), 1);
    chk("ovr_data_held",  32'(rx_if.rx_data),  32'h 3C);
    chk("ovr_pulses",     32'(n_ovr - s_ovr),  1);
    chk("ovr_rises",      32'(n_rise - s_rise), 1);
    chk("model_ovr",      32'({m_valid, m_data}), 32'h 13C);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    @(negedge clk);
    chk("accept_clears", 32'(rx_if.rx_valid), 0);
    rx_if.rx_ready = 1'b1;

    // 50-clk glitch on idle line: false start, busy for 9 ticks only
    s_rise = n_rise; s_busy = n_busy; s_ferr = n_ferr; s_ovr = n_ovr;
    rxd = 1'b0;
    repeat (50) @(negedge clk);
    idle(300);
    chk("glitch_busy_len_ok", 32'((n_busy - s_busy) >= 80 && (n_busy - s_busy) <= 110), 1);
    chk("glitch_no_byte",  32'(n_rise - s_rise), 0);
    chk("glitch_no_err",   32'((n_ferr - s_ferr) + (n_ovr - s_ovr)), 0);
    chk("glitch_idle",     32'(rx_if.rx_busy), 0);

    // 0x55 with low stop bit, line held low 3 bit times: one framing error,
    // receiver parked until the line goes high, then 0x81 decodes
    s_rise = n_rise; s_ferr = n_ferr;
    send_frame(8'h55, 1'b0, -1, 0, -1);
    rxd = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    chk("break_busy",   32'(rx_if.rx_busy),   1);
    chk("break_ferr",   32'(n_ferr - s_ferr), 1);
    chk("break_novalid", 32'(rx_if.rx_valid), 0);
    idle(100);
    chk("break_released", 32'(rx_if.rx_busy), 0);
    send_frame(8'h81, 1'b1, -1, 0, -1);
    idle(40);
    chk("after_break_rises", 32'(n_rise - s_rise), 1);
    chk("after_break_data",  32'(rise_data), 32'h 81);

    // 0xF0 with an inverted glitch over the middle sample of data bit 3 only
    // (neighbouring samples sit DIV clocks either side)
    send_frame(8'hF0, 1'b1, 4 * BIT + 8 * DIV - 9, 19, -1);
    idle(40);
    chk("vote_data", 32'(rise_data), 32'h F0);
    chk("model_vote", 32'(m_data), 32'h F0);

    // reset during data bit 4 of 0x12 aborts silently; 0x34 follows cleanly
    s_rise = n_rise; s_ferr = n_ferr; s_ovr = n_ovr;
    send_frame(8'h12, 1'b1, -1, 0, 5 * BIT + 50);
    idle(5);
    chk("rst_valid", 32'(rx_if.rx_valid), 0);
    chk("rst_data",  32'(rx_if.rx_data),  0);
    chk("rst_busy",  32'(rx_if.rx_busy),  0);
    idle(200);
    chk("rst_no_events", 32'((n_rise - s_rise) + (n_ferr - s_ferr) + (n_ovr - s_ovr)), 0);
    send_frame(8'h34, 1'b1, -1, 0, -1);
    idle(40);
    chk("post_rst_rises", 32'(n_rise - s_rise), 1);
    chk("post_rst_data",  32'(rise_data), 32'h 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 8N1 UART receiver with 16x oversampling and 3-sample majority voting on every bit.
- Pairs with the existing UART transmit path on the system's uart_rxd pin; also serves as the bench-side partner that decodes the DUT's uart_txd line.
- Delivers bytes on a valid/ready handshake and flags framing errors and overruns.

Parameters:
clk_freq, 50000000, system clock frequency in Hz
uart_baud_rate, 115200, line baud rate in bit/s
- Derived constant DIV = clk_freq / (uart_baud_rate*16), truncated. Elaboration error if DIV < 1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; synchronous, active-high
uart_rxd  in  1  asynchronous serial input, idle high
rx_data  out  8  received byte, stable while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts when rx_valid & rx_ready at a clk edge
rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
rx_overrun  out  1  one-cycle pulse: byte completed while rx_valid still 1
rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0; state=IDLE; sync flops=1; counters=0. Reset mid-frame aborts the frame with no error pulse.
- Input: 2-flop synchroniser, reset to 1. All decisions use the synchronised bit rxs.
- Tick generator: counter 0..DIV-1 produces a one-cycle tick at terminal count. The counter restarts at 0 on the IDLE->START transition, so tick phase aligns to the detected edge.
- Oversample counter os (4 bit) advances on each tick. Samples are taken at os=7, 8, 9. The majority of the 3 samples is the bit value, decided at os=9. os wraps 15->0 and advances the bit index.
- States:
  - IDLE: rxs=0 -> START (os=0).
  - START: at decision, majority=1 -> IDLE (false start, no pulse); else at os wrap -> DATA (bit=0).
  - DATA: decided bit is shifted in LSB first. After bit 7 wraps -> STOP.
  - STOP, decision at os=9:
    - majority=1 and rx_valid=0 -> load rx_data, rx_valid=1 next cycle, -> IDLE.
    - majority=1 and rx_valid=1 -> rx_overrun pulse, new byte dropped, old rx_data/rx_valid kept, -> IDLE.
    - majority=0 -> rx_frame_err pulse, byte discarded, -> BREAK.
  - BREAK: wait for rxs=1 -> IDLE. Prevents a held-low line (break) from being read as repeated start bits.
- STOP returns to IDLE at mid-stop-bit, so back-to-back frames with one stop bit are received.
- Handshake:
  - rx_valid clears on the cycle after an accept.
  - Accept and new-byte load in the same cycle: the new byte wins and rx_valid stays 1; no overrun.
  - rx_ready is ignored while rx_valid=0.
- Latency: line falling edge to rx_valid rising = 2 sync cycles + (9*16+9)*DIV tick periods + 1 cycle, within ±DIV cycles.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK}
  - OS_RATE=16 and sample points 7/8/9
  - function calc_div(clk_freq, baud)
  - Shared with the transmitter.
- Sub-module uart_baud_tick(clk, rst, restart, tick) parameterised by DIV. The transmitter reuses it.

Test Plan (clk_freq=50000000, uart_baud_rate=312500, so DIV=10 and 1 bit = 160 clk):
- Frame 0xA5 with rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5, about 1532 clk after the start edge; no error pulses.
- 0x3C then 0xC3 back-to-back, rx_ready=0 -> rx_data=0x3C held, rx_valid=1, one rx_overrun pulse. Then rx_ready=1 for 1 cycle -> rx_valid=0.
- 50-clk low glitch on idle line -> stays IDLE after START decision; rx_busy high about 100 clk then low; no rx_valid, no error pulses.
- Frame 0x55 with stop bit driven 0, line then held low for 3 bit times -> one rx_frame_err pulse, rx_valid=0, remains in BREAK until line high, then 0x81 received correctly.
- 20-clk inverted glitch centred on the os=8 sample of data bit 3 of 0xF0 -> majority vote still yields 0xF0.
- rst asserted for 1 cycle during data bit 4 of 0x12, line idle afterwards -> all outputs 0, state IDLE; next frame 0x34 received correctly.
